// File: rtl/mips_muldiv_pkg.sv
// Shared types and helpers for the MIPS multiply/divide unit.
package mips_muldiv_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  // Callers zero-extend into and truncate out of this width, so WIDTH up to 64 is supported.
  localparam int MAX_W = 128;

  function automatic logic [MAX_W-1:0] cond_negate(input logic [MAX_W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/mips_div_step.sv
// One restoring-division step: shift {remainder, quotient} left, trial-subtract the divisor.
module mips_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] remainder_in,
  input  logic [WIDTH-1:0] quotient_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remainder_out,
  output logic [WIDTH-1:0] quotient_out
);

  logic [WIDTH:0] shifted;
  logic           fits;

  always_comb begin
    shifted = {remainder_in, quotient_in[WIDTH-1]};
    fits    = (shifted >= {1'b0, divisor});
    // remainder_in < divisor always holds, so a successful subtraction fits in WIDTH bits
    remainder_out = fits ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
    quotient_out  = {quotient_in[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO. Define MULDIV_EARLY_OUT_EN to let a
// multiply finish as soon as its remaining multiplier bits are all zero.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int PW    = 2 * WIDTH;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    prod;    // MUL: {accumulator, multiplier}; DIV: {remainder, dividend->quotient}
  logic [WIDTH-1:0] opnd;    // multiplicand or divisor magnitude
  logic             sign_a;
  logic             sign_q;
  logic             is_div;
  logic             div_zero;

  logic             is_signed;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [PW-1:0]    mul_next;
  logic [PW-1:0]    prod_aligned;
  logic [PW-1:0]    prod_fixed;
  logic             mul_last;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  always_comb begin
    is_signed = (op == MULT) || (op == DIV);
    sa        = is_signed & a[WIDTH-1];
    sb        = is_signed & b[WIDTH-1];
    mag_a     = WIDTH'(cond_negate(MAX_W'(a), sa));
    mag_b     = WIDTH'(cond_negate(MAX_W'(b), sb));
  end

  always_comb begin
    mul_sum  = {1'b0, prod[PW-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, prod[WIDTH-1:1]};
`ifdef MULDIV_EARLY_OUT_EN
    // Stop once the unconsumed multiplier bits are zero; FIX performs the skipped right shifts.
    mul_last     = (mul_next[WIDTH-1:0] & ({WIDTH{1'b1}} >> (cnt + CNT_W'(1)))) == '0;
    prod_aligned = prod >> (CNT_W'(WIDTH) - cnt);
`else
    mul_last     = (cnt == CNT_W'(WIDTH - 1));
    prod_aligned = prod;
`endif
    prod_fixed = PW'(cond_negate(MAX_W'(prod_aligned), sign_q));
  end

  mips_div_step #(.WIDTH(WIDTH)) u_div_step (
    .remainder_in (prod[PW-1:WIDTH]),
    .quotient_in  (prod[WIDTH-1:0]),
    .divisor      (opnd),
    .remainder_out(rem_next),
    .quotient_out (quo_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      prod     <= '0;
      opnd     <= '0;
      sign_a   <= 1'b0;
      sign_q   <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              MTHI: begin
                hi   <= a;
                done <= 1'b1;
              end
              MTLO: begin
                lo   <= a;
                done <= 1'b1;
              end
              MULT, MULTU: begin
                prod     <= {{WIDTH{1'b0}}, mag_b};
                opnd     <= mag_a;
                sign_a   <= sa;
                sign_q   <= sa ^ sb;
                is_div   <= 1'b0;
                div_zero <= 1'b0;
                cnt      <= '0;
                busy     <= 1'b1;
                state    <= S_MUL;
              end
              DIV, DIVU: begin
                opnd   <= mag_b;
                sign_a <= sa;
                sign_q <= sa ^ sb;
                is_div <= 1'b1;
                cnt    <= '0;
                busy   <= 1'b1;
                if (b == '0) begin
                  prod     <= {{WIDTH{1'b0}}, a};
                  div_zero <= 1'b1;
                  state    <= S_FIX;
                end else begin
                  prod     <= {{WIDTH{1'b0}}, mag_a};
                  div_zero <= 1'b0;
                  state    <= S_DIV;
                end
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          prod <= mul_next;
          cnt  <= cnt + CNT_W'(1);
          if (mul_last) state <= S_FIX;
        end
        S_DIV: begin
          prod <= {rem_next, quo_next};
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
        end
        S_FIX: begin
          if (is_div) begin
            hi <= div_zero ? prod[WIDTH-1:0]
                           : WIDTH'(cond_negate(MAX_W'(prod[PW-1:WIDTH]), sign_a));
            lo <= div_zero ? '1
                           : WIDTH'(cond_negate(MAX_W'(prod[WIDTH-1:0]), sign_q));
          end else begin
            {hi, lo} <= prod_fixed;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed and random operations checked
// against an arithmetic reference of HI/LO and the expected done latency.
module tb_mips_muldiv_unit;
  import mips_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  muldiv_op_t  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  always #5 clk = ~clk;

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  // Reference: HI/LO after an operation, using plain 64-bit arithmetic.
  function automatic void apply_model(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
    longint      sx;
    longint      sy;
    longint      q;
    longint      r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      MULT: begin
        p = sx * sy;
        {exp_hi, exp_lo} = p;
      end
      MULTU: begin
        p = {32'h0, x} * {32'h0, y};
        {exp_hi, exp_lo} = p;
      end
      DIV: begin
        if (y == 32'h0) begin
          exp_hi = x;
          exp_lo = 32'hFFFF_FFFF;
        end else begin
          q = sx / sy;
          r = sx % sy;
          exp_lo = q[31:0];
          exp_hi = r[31:0];
        end
      end
      DIVU: begin
        if (y == 32'h0) begin
          exp_hi = x;
          exp_lo = 32'hFFFF_FFFF;
        end else begin
          exp_lo = x / y;
          exp_hi = x % y;
        end
      end
      MTHI: exp_hi = x;
      MTLO: exp_lo = x;
      default: ;
    endcase
  endfunction

  // Reference: number of clock edges after the start edge until done is visible.
  function automatic int exp_lat(input muldiv_op_t o, input logic [31:0] y);
    case (o)
      MTHI, MTLO: return 0;
      DIV, DIVU:  return (y == 32'h0) ? 1 : 33;
      default: begin
`ifdef MULDIV_EARLY_OUT_EN
        logic [31:0] m;
        int          steps;
        m = (o == MULT && y[31]) ? -y : y;
        steps = 1;
        for (int i = 0; i < 32; i++) if (m[i]) steps = i + 1;
        return steps + 1;
`else
        return 33;
`endif
      end
    endcase
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Drives one start and waits (bounded) for done. When inject >= 0, an MTHI start is
  // pulsed on the edge after that many cycles so it lands while the unit is busy.
  task automatic issue(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y,
                       input int inject, output int lat, output int bcnt,
                       output logic [31:0] oh, output logic [31:0] ol, output logic dpost);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 0; bcnt = 0;
    while (lat < 200) begin
      @(negedge clk);
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) break;
      if (lat == inject) begin
        start = 1'b1; op = MTHI; a = $urandom;
      end
      @(posedge clk);
      #1 start = 1'b0;
      lat++;
    end
    oh = hi; ol = lo;
    @(negedge clk);
    dpost = done;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = MULT; a = '0; b = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({hi, lo} !== 64'h0) begin
      n_fail++; $display("FAIL reset_hilo: got %h_%h want 0", hi, lo);
    end
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags: busy=%b done=%b want 0 0", busy, done);
    end
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_mthi_mtlo();
    int busy_seen = 0;
    @(negedge clk);
    start = 1'b1; op = MTHI; a = 32'h1234;
    @(posedge clk);
    #1 op = MTLO; a = 32'h5678;
    apply_model(MTHI, 32'h1234, 32'h0);
    @(negedge clk);
    if (busy !== 1'b0) busy_seen++;
    n_tests++;
    if (hi !== exp_hi || lo !== exp_lo || done !== 1'b1) begin
      n_fail++; $display("FAIL mthi: hi=%h lo=%h done=%b want %h %h 1", hi, lo, done, exp_hi, exp_lo);
    end
    @(posedge clk);
    #1 start = 1'b0;
    apply_model(MTLO, 32'h5678, 32'h0);
    @(negedge clk);
    if (busy !== 1'b0) busy_seen++;
    n_tests++;
    if (hi !== 32'h1234 || lo !== 32'h5678 || done !== 1'b1) begin
      n_fail++; $display("FAIL mtlo: hi=%h lo=%h done=%b want 1234 5678 1", hi, lo, done);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy_seen != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mt_busy_done: done=%b busy_seen=%0d want 0 0", done, busy_seen);
    end
  endtask

  task automatic test_directed();
    muldiv_op_t  d_op [10] = '{MULTU, MULT, DIV, DIVU, DIV, DIVU, MULTU, MULT, MULT, DIV};
    logic [31:0] d_a  [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000,
                               32'd5, 32'd5, 32'h0001_2345, 32'd7, 32'd7};
    logic [31:0] d_b  [10] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFF,
                               32'd0, 32'd1, 32'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFE};
    int lat, bcnt, el;
    logic [31:0] oh, ol;
    logic dpost;
    for (int i = 0; i < 10; i++) begin
      issue(d_op[i], d_a[i], d_b[i], -1, lat, bcnt, oh, ol, dpost);
      apply_model(d_op[i], d_a[i], d_b[i]);
      el = exp_lat(d_op[i], d_b[i]);
      n_tests++;
      if (oh !== exp_hi || ol !== exp_lo) begin
        n_fail++; $display("FAIL dir%0d_result: hi=%h lo=%h want %h %h", i, oh, ol, exp_hi, exp_lo);
      end
      n_tests++;
      if (lat != el || bcnt != el) begin
        n_fail++; $display("FAIL dir%0d_latency: lat=%0d busy=%0d want %0d", i, lat, bcnt, el);
      end
      n_tests++;
      if (dpost !== 1'b0) begin
        n_fail++; $display("FAIL dir%0d_done_pulse: done=%b want 0", i, dpost);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat, bcnt, el;
    logic [31:0] oh, ol;
    logic dpost;
    issue(MULT, 32'h0000_1234, 32'h9000_0000, 5, lat, bcnt, oh, ol, dpost);
    apply_model(MULT, 32'h0000_1234, 32'h9000_0000);
    el = exp_lat(MULT, 32'h9000_0000);
    n_tests++;
    if (oh !== exp_hi || ol !== exp_lo || lat != el) begin
      n_fail++; $display("FAIL busy_ignore_mid: hi=%h lo=%h lat=%0d want %h %h %0d", oh, ol, lat, exp_hi, exp_lo, el);
    end
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, lat, bcnt, oh, ol, dpost);
    apply_model(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n_tests++;
    if (oh !== exp_hi || ol !== exp_lo || lat != 33) begin
      n_fail++; $display("FAIL busy_ignore_last: hi=%h lo=%h lat=%0d want %h %h 33", oh, ol, lat, exp_hi, exp_lo);
    end
    @(negedge clk);
    n_tests++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      n_fail++; $display("FAIL busy_ignore_after: hi=%h lo=%h want %h %h", hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    int lat, bcnt, el;
    logic [31:0] oh, ol;
    logic dpost;
    @(negedge clk);
    start = 1'b1; op = DIV; a = $urandom; b = $urandom | 32'h1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({hi, lo} !== 64'h0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_reset: hi=%h lo=%h busy=%b done=%b want 0 0 0 0", hi, lo, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    n_tests++;
    if (dones != 0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++; $display("FAIL abort_no_finish: events=%0d hi=%h lo=%h want 0 0 0", dones, hi, lo);
    end
    issue(MULTU, 32'd6, 32'd7, -1, lat, bcnt, oh, ol, dpost);
    apply_model(MULTU, 32'd6, 32'd7);
    el = exp_lat(MULTU, 32'd7);
    n_tests++;
    if (oh !== 32'h0 || ol !== 32'd42 || lat != el) begin
      n_fail++; $display("FAIL abort_then_mult: hi=%h lo=%h lat=%0d want 0 2a %0d", oh, ol, lat, el);
    end
  endtask

  task automatic test_random();
    int lat, bcnt, el;
    logic [31:0] x, y, oh, ol;
    logic dpost;
    muldiv_op_t o;
    for (int i = 0; i < 40; i++) begin
      o = muldiv_op_t'(3'($urandom_range(0, 5)));
      x = rand_opnd();
      y = rand_opnd();
      issue(o, x, y, -1, lat, bcnt, oh, ol, dpost);
      apply_model(o, x, y);
      el = exp_lat(o, y);
      n_tests++;
      if (oh !== exp_hi || ol !== exp_lo || lat != el || bcnt != el || dpost !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d op=%0d a=%h b=%h: hi=%h lo=%h lat=%0d busy=%0d dpost=%b want %h %h %0d",
                 i, o, x, y, oh, ol, lat, bcnt, dpost, exp_hi, exp_lo, el);
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0; op = muldiv_op_t'(3'($urandom_range(0, 5))); a = $urandom; b = $urandom;
      @(negedge clk);
      n_tests++;
      if (hi !== exp_hi || lo !== exp_lo || done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL hold%0d: hi=%h lo=%h done=%b busy=%b want %h %h 0 0", i, hi, lo, done, busy, exp_hi, exp_lo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_directed();
    test_busy_ignore();
    test_reset_abort();
    test_random();
    test_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
